unum4_div_arbiter: RTL and testbench

- Round-robin controller that shares one iterative subtract-shift divider (DATA_W-bit, signed/unsigned) among N_REQ requesters.
- Accepts a request per requester over a valid/ready handshake.
- Sequences the divider's en/done protocol, captures the quotient and remainder, and returns them on a shared response bus tagged with the requester id.
- Zero divisors bypass the divider.

---
 rtl/unum4_div_arbiter.sv | 166 ++++++++++++++++
 tb/tb_unum4_div_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/unum4_div_arbiter.sv
// Round-robin front end that shares one iterative divider among N_REQ requesters.
// Zero divisors are answered directly; a stuck divider is cut off after TIMEOUT cycles.
module unum4_div_arbiter #(
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = DATA_W + 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_sign,
  input  logic [N_REQ*DATA_W-1:0]   req_dividend,
  input  logic [N_REQ*DATA_W-1:0]   req_divisor,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic [DATA_W-1:0]         rsp_remainder,
  output logic                      rsp_dbz,
  output logic                      rsp_err,
  output logic                      div_en,
  output logic                      div_sign,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_remainder
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int         CNT_W   = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;

  logic              found;
  logic [ID_W-1:0]   gnt;
  logic [ID_W:0]     sum;
  logic [ID_W-1:0]   idx;
  logic [N_REQ-1:0]  onehot;

  logic [DATA_W-1:0] dvd_arr [N_REQ];
  logic [DATA_W-1:0] dvs_arr [N_REQ];
  logic [DATA_W-1:0] sel_dvd;
  logic [DATA_W-1:0] sel_dvs;
  logic              sel_sgn;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign dvd_arr[gi] = req_dividend[gi*DATA_W +: DATA_W];
    assign dvs_arr[gi] = req_divisor[gi*DATA_W +: DATA_W];
  end

  // Round-robin scan starting just above the last winner, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum   = {1'b0, ptr} + (ID_W+1)'(k);
      idx   = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
      gnt   = (req_valid[idx] && !found) ? idx : gnt;
      found = found | req_valid[idx];
    end
  end

  // One-hot accept vector and operand mux for the winning requester.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      onehot[i] = found && (gnt == ID_W'(i));
    end
    sel_dvd = dvd_arr[gnt];
    sel_dvs = dvs_arr[gnt];
    sel_sgn = req_sign[gnt];
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= ID_W'(N_REQ - 1);
      cnt           <= '0;
      req_ready     <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_err       <= 1'b0;
      div_en        <= 1'b0;
      div_sign      <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        ST_IDLE: begin
          div_en <= 1'b0;
          if (found) begin
            req_ready    <= onehot;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
            div_sign     <= sel_sgn;
            rsp_id       <= gnt;
            ptr          <= gnt;
            cnt          <= '0;
            // A zero divisor never reaches the divider.
            if (sel_dvs == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dvd;
              rsp_dbz       <= 1'b1;
              rsp_valid     <= 1'b1;
              state         <= ST_RESP;
            end else begin
              div_en <= 1'b1;
              state  <= ST_BUSY;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            div_en        <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_err       <= 1'b1;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            div_en        <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dbz   <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: begin
          div_en    <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unum4_div_arbiter.sv
// Directed bench for unum4_div_arbiter with a behavioural divider of fixed latency.
module tb_unum4_div_arbiter;
  localparam int DATA_W  = 32;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = DATA_W + 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid, req_ready, req_sign;
  logic [N_REQ*DATA_W-1:0] req_dividend, req_divisor;
  logic                    rsp_valid, rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_quotient, rsp_remainder;
  logic                    rsp_dbz, rsp_err;
  logic                    div_en, div_sign, div_done;
  logic [DATA_W-1:0]       div_dividend, div_divisor, div_quotient, div_remainder;

  int checks = 0;
  int failures = 0;
  int dcnt = 0;
  int en_cnt = 0;
  logic stub_off = 1'b0;

  int          ord3 [5] = '{0, 1, 2, 3, 0};
  logic [31:0] q3   [5] = '{32'd100, 32'd6, 32'h0FFF_FFFF, 32'hFFFF_FFFA, 32'd9};
  logic [31:0] r3   [5] = '{32'd0, 32'd2, 32'd15, 32'hFFFF_FFFE, 32'd0};

  unum4_div_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err), .div_en(div_en),
    .div_sign(div_sign), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // Divider stand-in: done in the 37th enabled cycle, cleared whenever en is low.
  always @(posedge clk) begin
    if (!div_en) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_done = div_en && !stub_off && (dcnt == DATA_W + 4);
  assign div_quotient  = (div_divisor == '0) ? '0 :
                         div_sign ? DATA_W'($signed(div_dividend) / $signed(div_divisor)) :
                                    div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? '0 :
                         div_sign ? DATA_W'($signed(div_dividend) % $signed(div_divisor)) :
                                    div_dividend % div_divisor;

  always @(negedge clk) begin
    if (div_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs);
    req_valid[id] = 1'b1;
    req_sign[id] = sgn;
    req_dividend[id*DATA_W +: DATA_W] = dvd;
    req_divisor[id*DATA_W +: DATA_W] = dvs;
  endtask

  task automatic wait_grant(input string tag, output int g);
    int n;
    n = 0;
    g = -1;
    while (n < 60 && g < 0) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
    end
    if (g < 0) check({tag, "_grant_timeout"}, 64'd0, 64'd1);
    else req_valid[g] = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int id, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input logic eerr, input int elat);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_q"}, 64'(rsp_quotient), 64'(eq));
    check({tag, "_r"}, 64'(rsp_remainder), 64'(er));
    check({tag, "_flags"}, {62'd0, rsp_dbz, rsp_err}, {62'd0, edbz, eerr});
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done"}, {61'd0, rsp_valid, rsp_dbz, rsp_err}, 64'd0);
  endtask

  task automatic run_one(input string tag, input int id, input logic sgn, input logic [31:0] dvd,
                         input logic [31:0] dvs, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input logic eerr, input int elat, input int een);
    int g, e0;
    @(negedge clk);
    set_req(id, sgn, dvd, dvs);
    e0 = en_cnt;
    wait_grant(tag, g);
    check({tag, "_ready"}, 64'(req_ready), 64'(1) << id);
    finish_op(tag, id, eq, er, edbz, eerr, elat);
    check({tag, "_en_cycles"}, 64'(en_cnt - e0), 64'(een));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    logic stable, rdy_seen, rsp_seen;
    logic [68:0] snap;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_sign = '0; req_dividend = '0; req_divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {55'd0, req_ready, rsp_valid, rsp_dbz, rsp_err, div_en, div_sign}, 64'd0);
    check("reset_res", {rsp_quotient, rsp_remainder}, 64'd0);
    check("reset_ops", {div_dividend, div_divisor}, 64'd0);
    check("reset_id", 64'(rsp_id), 64'd0);
    rst = 1'b0;

    run_one("t1", 2, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 37, 37);
    run_one("t2a", 1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 37, 37);
    run_one("t2b", 3, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 37, 37);

    // Contention: all four pending, requester 0 re-requests after its response.
    @(negedge clk);
    set_req(0, 1'b0, 32'd1000, 32'd10);
    set_req(1, 1'b0, 32'd50, 32'd8);
    set_req(2, 1'b0, 32'hFFFF_FFFF, 32'd16);
    set_req(3, 1'b1, 32'hFFFF_FFEC, 32'd3);
    for (int s = 0; s < 5; s++) begin
      wait_grant("t3", g);
      check("t3_order", 64'(g), 64'(ord3[s]));
      finish_op("t3", ord3[s], q3[s], r3[s], 1'b0, 1'b0, 37);
      if (s == 0) set_req(0, 1'b0, 32'd81, 32'd9);
    end

    run_one("t4", 1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 0, 0);

    // Backpressure with requester 1 waiting behind the stalled response.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 1'b0, 32'd200, 32'd9);
    wait_grant("t5", g);
    while (!rsp_valid && dcnt < 100) @(negedge clk);
    check("t5_q", 64'(rsp_quotient), 64'd22);
    set_req(1, 1'b0, 32'd30, 32'd4);
    snap = {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err, rsp_valid};
    stable = 1'b1; rdy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err, rsp_valid} !== snap) stable = 1'b0;
      if (req_ready != '0) rdy_seen = 1'b1;
    end
    check("t5_stable", 64'(stable), 64'd1);
    check("t5_no_ready", 64'(rdy_seen), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_idle_gap", {62'd0, rsp_valid, div_en}, 64'd0);
    wait_grant("t5b", g);
    check("t5b_grant", 64'(g), 64'd1);
    finish_op("t5b", 1, 32'd7, 32'd2, 1'b0, 1'b0, 37);

    // Reset in the middle of a division.
    @(negedge clk);
    set_req(2, 1'b0, 32'd500, 32'd5);
    wait_grant("t6", g);
    repeat (10) @(negedge clk);
    check("t6_busy", 64'(div_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_ctl", {55'd0, req_ready, rsp_valid, rsp_dbz, rsp_err, div_en, div_sign}, 64'd0);
    check("t6_rst_res", {rsp_quotient, rsp_remainder}, 64'd0);
    check("t6_rst_ops", {div_dividend, div_divisor}, 64'd0);
    rsp_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    check("t6_no_rsp", 64'(rsp_seen), 64'd0);
    set_req(3, 1'b0, 32'd1234, 32'd10);
    set_req(0, 1'b0, 32'd77, 32'd7);
    wait_grant("t6a", g);
    check("t6a_first", 64'(g), 64'd0);
    finish_op("t6a", 0, 32'd11, 32'd0, 1'b0, 1'b0, 37);
    wait_grant("t6b", g);
    check("t6b_second", 64'(g), 64'd3);
    finish_op("t6b", 3, 32'd123, 32'd4, 1'b0, 1'b0, 37);

    // Divider that never finishes.
    stub_off = 1'b1;
    run_one("t6_to", 2, 1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, TIMEOUT, TIMEOUT);
    stub_off = 1'b0;
    run_one("t7", 1, 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0, 37, 37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
